// File: rtl/uart_cmd_ctrl_if.sv
// Byte-stream input, register-write handshake and status signals of the UART command sequencer.
// The master modport belongs to whoever feeds bytes and acknowledges writes.
interface uart_cmd_ctrl_if;
  logic        i_Rx_DV;
  logic [7:0]  i_Rx_Byte;
  logic        o_Wr_En;
  logic [7:0]  o_Wr_Addr;
  logic [31:0] o_Wr_Data;
  logic        i_Wr_Ack;
  logic        o_Busy;
  logic        o_Csum_Err;
  logic        o_Timeout;
  logic        o_Overrun;
  logic [7:0]  o_Err_Count;

  modport master (
    output i_Rx_DV, i_Rx_Byte, i_Wr_Ack,
    input  o_Wr_En, o_Wr_Addr, o_Wr_Data, o_Busy,
    input  o_Csum_Err, o_Timeout, o_Overrun, o_Err_Count
  );

  modport slave (
    input  i_Rx_DV, i_Rx_Byte, i_Wr_Ack,
    output o_Wr_En, o_Wr_Addr, o_Wr_Data, o_Busy,
    output o_Csum_Err, o_Timeout, o_Overrun, o_Err_Count
  );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Assembles SYNC/ADDR/D3..D0/CSUM frames from UART bytes and issues one register write per
// frame with a valid XOR checksum; reports checksum errors, inter-byte timeouts and overruns.
module uart_cmd_ctrl #(
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int unsigned TIMEOUT_CLKS = 2000000,
  parameter int unsigned TMO_W        = 24
) (
  input  logic           osc_clk,
  input  logic           i_Reset,
  uart_cmd_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_CSUM,
    S_WRITE
  } state_t;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

  state_t            state_q;
  logic [7:0]        addr_q;
  logic [7:0]        xor_q;
  logic [31:0]       data_q;
  logic [1:0]        idx_q;
  logic [TMO_W-1:0]  tmo_q;
  logic              wr_en_q;
  logic [7:0]        wr_addr_q;
  logic [31:0]       wr_data_q;
  logic              busy_q;
  logic              csum_err_q;
  logic              timeout_q;
  logic              overrun_q;
  logic [7:0]        err_cnt_q;

  logic              in_frame;
  logic              tmo_hit_d;
  logic              csum_err_d;
  logic              overrun_d;
  logic              err_d;

  // A byte in the terminal-count cycle always wins over the timeout.
  always_comb begin
    in_frame   = (state_q == S_ADDR) || (state_q == S_DATA) || (state_q == S_CSUM);
    tmo_hit_d  = in_frame && !bus.i_Rx_DV && (tmo_q == TMO_LAST);
    csum_err_d = (state_q == S_CSUM) && bus.i_Rx_DV && (bus.i_Rx_Byte != xor_q);
    overrun_d  = (state_q == S_WRITE) && bus.i_Rx_DV;
    err_d      = tmo_hit_d || csum_err_d || overrun_d;
  end

  always_ff @(posedge osc_clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      xor_q      <= '0;
      data_q     <= '0;
      idx_q      <= '0;
      tmo_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      csum_err_q <= 1'b0;
      timeout_q  <= 1'b0;
      overrun_q  <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      csum_err_q <= csum_err_d;
      timeout_q  <= tmo_hit_d;
      overrun_q  <= overrun_d;
      if (err_d && (err_cnt_q != 8'hFF)) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end

      case (state_q)
        S_IDLE: begin
          if (bus.i_Rx_DV && (bus.i_Rx_Byte == SYNC_BYTE)) begin
            state_q <= S_ADDR;
            busy_q  <= 1'b1;
            tmo_q   <= '0;
          end
        end

        // No resync: a SYNC value here is a legitimate address.
        S_ADDR: begin
          if (bus.i_Rx_DV) begin
            addr_q  <= bus.i_Rx_Byte;
            xor_q   <= bus.i_Rx_Byte;
            idx_q   <= '0;
            tmo_q   <= '0;
            state_q <= S_DATA;
          end else if (tmo_hit_d) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            tmo_q <= tmo_q + TMO_ONE;
          end
        end

        S_DATA: begin
          if (bus.i_Rx_DV) begin
            data_q <= {data_q[23:0], bus.i_Rx_Byte};
            xor_q  <= xor_q ^ bus.i_Rx_Byte;
            idx_q  <= idx_q + 2'd1;
            tmo_q  <= '0;
            if (idx_q == 2'd3) begin
              state_q <= S_CSUM;
            end
          end else if (tmo_hit_d) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            tmo_q <= tmo_q + TMO_ONE;
          end
        end

        S_CSUM: begin
          if (bus.i_Rx_DV) begin
            tmo_q <= '0;
            if (bus.i_Rx_Byte == xor_q) begin
              wr_addr_q <= addr_q;
              wr_data_q <= data_q;
              wr_en_q   <= 1'b1;
              state_q   <= S_WRITE;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else if (tmo_hit_d) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            tmo_q <= tmo_q + TMO_ONE;
          end
        end

        // Bytes arriving here are counted as overruns above and otherwise dropped.
        S_WRITE: begin
          if (bus.i_Wr_Ack) begin
            wr_en_q <= 1'b0;
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= S_IDLE;
          wr_en_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_Wr_En     = wr_en_q;
  assign bus.o_Wr_Addr   = wr_addr_q;
  assign bus.o_Wr_Data   = wr_data_q;
  assign bus.o_Busy      = busy_q;
  assign bus.o_Csum_Err  = csum_err_q;
  assign bus.o_Timeout   = timeout_q;
  assign bus.o_Overrun   = overrun_q;
  assign bus.o_Err_Count = err_cnt_q;

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
- Command sequencer that sits between the UART receiver and the receiver's configuration registers (NCO frequency, gain, filter select, and similar).
- Consumes the one-cycle byte strobe and byte from the UART receiver in the osc_clk domain.
- Assembles fixed-length binary command frames, checks each frame and then issues one 32-bit register write per valid frame through a req/ack handshake.
- Detects and reports frame errors, inter-byte timeouts and overruns.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CLKS, 2000000, maximum osc_clk cycles allowed between bytes inside a frame.
- TMO_W, 24, width of the timeout counter; must hold TIMEOUT_CLKS-1.

Ports:
- osc_clk  in  1  system clock; the only clock.
- i_Reset  in  1  asynchronous, active-high reset.
- i_Rx_DV  in  1  byte-valid strobe from the UART receiver; one cycle wide.
- i_Rx_Byte  in  8  received byte; valid when i_Rx_DV=1.
- o_Wr_En  out  1  write request; held high until acknowledged.
- o_Wr_Addr  out  8  register address; stable while o_Wr_En=1.
- o_Wr_Data  out  32  register data; stable while o_Wr_En=1.
- i_Wr_Ack  in  1  write accepted by the register side.
- o_Busy  out  1  high in every state except IDLE.
- o_Csum_Err  out  1  one-cycle pulse on checksum mismatch.
- o_Timeout  out  1  one-cycle pulse on inter-byte timeout.
- o_Overrun  out  1  one-cycle pulse when a byte arrives in WRITE.
- o_Err_Count  out  8  saturating count of all three error types.

Behaviour:
- Frame format: SYNC, ADDR, D3, D2, D1, D0 (data MSB first), CSUM.
- Expected CSUM = ADDR ^ D3 ^ D2 ^ D1 ^ D0.
- Reset (asynchronous, any state): state=IDLE; all outputs 0; o_Err_Count=0; shift register, byte index and timeout counter cleared. A write in progress is abandoned and o_Wr_En drops immediately.
- All state and outputs are registered on posedge osc_clk.
- Bytes are acted on only in cycles where i_Rx_DV=1.
- IDLE:
  - byte==SYNC_BYTE -> ADDR.
  - Any other byte is ignored silently; no error is raised.
- ADDR:
  - Any byte is latched as the address, including a byte equal to SYNC_BYTE; there is no resync.
  - Index=0 -> DATA.
- DATA:
  - Each byte is shifted into the 32-bit data register: data <= {data[23:0], byte}.
  - Running XOR is updated.
  - After the 4th byte (index 3) -> CSUM.
- CSUM:
  - byte==running XOR: o_Wr_Addr and o_Wr_Data load and o_Wr_En=1 on the next cycle -> WRITE.
  - Mismatch: o_Csum_Err pulses for 1 cycle -> IDLE; no write is issued.
- WRITE:
  - o_Wr_En held high with address and data frozen.
  - i_Wr_Ack=1 in any cycle where o_Wr_En=1, including the first -> o_Wr_En=0 next cycle -> IDLE.
  - There is no ack timeout.
  - i_Rx_DV=1 in WRITE: the byte is discarded, o_Overrun pulses, and the state is unchanged.
  - If ack and a byte arrive in the same cycle, the byte is discarded (overrun) and the ack is still honoured.
- Latency: the first o_Wr_En cycle is the cycle after the clock edge that samples the CSUM strobe.
- Timeout:
  - The counter runs only in ADDR, DATA and CSUM.
  - It clears to 0 on every accepted byte and on entry to ADDR.
  - When the counter reaches TIMEOUT_CLKS-1 with no byte present: o_Timeout pulses -> IDLE, and partial frame data is discarded.
  - A byte and terminal count in the same cycle: the byte wins and no timeout is raised.
- Error counter: increments by 1 for each error pulse and saturates at 255. The three errors are mutually exclusive per cycle by construction, so the maximum increment is 1.
- o_Busy = (state != IDLE), registered.
- Running XOR width is 8 bits and initialises to ADDR on the ADDR byte.

Test Plan:
- Valid frame: bytes A5 10 12 34 56 78 18 with 20-cycle gaps -> o_Wr_En rises 1 cycle after the 0x18 strobe, o_Wr_Addr=0x10, o_Wr_Data=0x12345678; i_Wr_Ack after 5 cycles -> o_Wr_En low next cycle, o_Busy low, o_Err_Count=0.
- Bad checksum: A5 10 12 34 56 78 19 -> o_Csum_Err single pulse, no o_Wr_En, o_Err_Count=1, then the valid frame from scenario 1 completes normally.
- Timeout (TIMEOUT_CLKS=100): A5 10 12, then silence -> o_Timeout pulses exactly 100 cycles after the 0x12 strobe, state IDLE; a byte landing on cycle 99 prevents the timeout.
- Overrun: valid frame, ack withheld, then byte 0x55 arrives -> o_Overrun pulse, o_Wr_Addr/o_Wr_Data unchanged; ack in the same cycle as a byte -> write completes and overrun is also reported.
- Garbage and sync: 00 FF 5A before A5 ... -> ignored, no errors; A5 A5 00 00 00 00 A5 -> write to address 0xA5 with data 0x00000000.
- Reset mid-frame and mid-WRITE: assert i_Reset asynchronously -> o_Wr_En drops without waiting for a clock, all outputs 0, o_Err_Count=0; the next full frame decodes correctly.
